// File: rtl/adc_cmd_scheduler.sv
// rtl/adc_cmd_scheduler.sv - ADC register-write scheduler: init sequence, DES on/off and user writes over a 3-wire serial port
module adc_cmd_scheduler #(
    parameter int          CLK_DIV      = 4,
    parameter int          GAP_CYCLES   = 8,
    parameter logic [3:0]  DES_ADDR     = 4'h9,
    parameter logic [15:0] DES_ON_DATA  = 16'h8000,
    parameter logic [15:0] DES_OFF_DATA = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        des_enable,
    input  logic        des_disable,
    input  logic        wr_req,
    input  logic [3:0]  wr_addr,
    input  logic [15:0] wr_data,
    output logic        wr_ack,
    output logic        busy,
    output logic        frame_done,
    output logic        des_active,
    output logic        sclk,
    output logic        sdata,
    output logic        select
);

    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;
    typedef enum logic [2:0] {SRC_NONE, SRC_INIT, SRC_DIS, SRC_EN, SRC_WR} src_t;

    state_t        state, state_nx;
    src_t          sel_src, cur_src;
    logic          init_pend, dis_pend, en_pend;
    logic          init_rem;
    logic [1:0]    next_idx;
    logic [1:0]    sel_idx;
    logic [3:0]    sel_addr, cur_addr;
    logic [15:0]   sel_data;
    logic [31:0]   sel_frame, shreg;
    logic [DW-1:0] div_cnt;
    logic          phase;
    logic [4:0]    bit_cnt;
    logic [GW-1:0] gap_cnt;
    logic          des_state;
    logic          any_req, load_go, bit_end, shift_done, gap_done;

    function automatic logic [19:0] init_entry(input logic [1:0] idx);
        case (idx)
            2'd0:    return {4'h1, 16'hB2FF};
            2'd1:    return {4'h2, 16'h007F};
            default: return {4'h3, 16'h807F};
        endcase
    endfunction

    // An unfinished init sequence outranks everything except a fresh init pulse,
    // so nothing can be interleaved between its entries.
    always_comb begin
        sel_src  = SRC_NONE;
        sel_idx  = 2'd0;
        sel_addr = 4'h0;
        sel_data = 16'h0000;
        if (init_pend) begin
            sel_src = SRC_INIT;
            sel_idx = 2'd0;
        end else if (init_rem) begin
            sel_src = SRC_INIT;
            sel_idx = next_idx;
        end else if (dis_pend) begin
            sel_src = SRC_DIS;
        end else if (en_pend) begin
            sel_src = SRC_EN;
        end else if (wr_req) begin
            sel_src = SRC_WR;
        end
        case (sel_src)
            SRC_INIT: {sel_addr, sel_data} = init_entry(sel_idx);
            SRC_DIS:  begin sel_addr = DES_ADDR; sel_data = DES_OFF_DATA; end
            SRC_EN:   begin sel_addr = DES_ADDR; sel_data = DES_ON_DATA;  end
            SRC_WR:   begin sel_addr = wr_addr;  sel_data = wr_data;      end
            default:  begin sel_addr = 4'h0;     sel_data = 16'h0000;     end
        endcase
        sel_frame = {12'h001, sel_addr, sel_data};
    end

    assign any_req    = init_pend | init_rem | dis_pend | en_pend | wr_req
                      | init | des_enable | des_disable;
    assign load_go    = (state == LOAD) && (sel_src != SRC_NONE);
    assign bit_end    = (state == SHIFT) && (div_cnt == DIV_LAST);
    assign shift_done = bit_end && phase && (bit_cnt == 5'd31);
    assign gap_done   = (state == GAP) && (gap_cnt == GAP_LAST);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_req) state_nx = LOAD;
            LOAD:    state_nx = load_go ? SHIFT : IDLE;
            SHIFT:   if (shift_done) state_nx = GAP;
            GAP:     if (gap_done) state_nx = any_req ? LOAD : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_pend <= 1'b0;
            dis_pend  <= 1'b0;
            en_pend   <= 1'b0;
            init_rem  <= 1'b0;
            next_idx  <= 2'd0;
            cur_src   <= SRC_NONE;
            cur_addr  <= 4'h0;
            shreg     <= 32'h0;
            div_cnt   <= '0;
            phase     <= 1'b0;
            bit_cnt   <= 5'd0;
            gap_cnt   <= '0;
            des_state <= 1'b0;
        end else begin
            if (init)                                  init_pend <= 1'b1;
            else if (load_go && sel_src == SRC_INIT)   init_pend <= 1'b0;

            // A disable wins a same-cycle collision and cancels any pending enable.
            if (des_disable)                           dis_pend <= 1'b1;
            else if (des_enable)                       dis_pend <= 1'b0;
            else if (load_go && sel_src == SRC_DIS)    dis_pend <= 1'b0;

            if (des_enable && !des_disable)            en_pend <= 1'b1;
            else if (des_disable)                      en_pend <= 1'b0;
            else if (load_go && sel_src == SRC_EN)     en_pend <= 1'b0;

            if (load_go) begin
                shreg    <= sel_frame;
                cur_src  <= sel_src;
                cur_addr <= sel_addr;
                init_rem <= (sel_src == SRC_INIT) && (sel_idx != 2'd2);
                if (sel_src == SRC_INIT) next_idx <= sel_idx + 2'd1;
                div_cnt  <= '0;
                phase    <= 1'b0;
                bit_cnt  <= 5'd0;
            end

            if (state == SHIFT) begin
                if (bit_end) begin
                    div_cnt <= '0;
                    if (!phase) begin
                        phase <= 1'b1;
                    end else begin
                        phase <= 1'b0;
                        if (!shift_done) begin
                            bit_cnt <= bit_cnt + 5'd1;
                            shreg   <= {shreg[30:0], 1'b0};
                        end
                    end
                end else begin
                    div_cnt <= div_cnt + DW'(1);
                end
            end

            if (shift_done)          gap_cnt <= '0;
            else if (state == GAP)   gap_cnt <= gap_cnt + GW'(1);

            if (gap_done && (cur_src == SRC_EN || cur_src == SRC_DIS) && cur_addr == DES_ADDR)
                des_state <= (cur_src == SRC_EN);
        end
    end

    // Outputs are forced to their idle levels for as long as rst is held.
    assign sclk       = !rst && (state == SHIFT) && phase;
    assign select     = rst || !(load_go || state == SHIFT);
    assign sdata      = !rst && (load_go ? sel_frame[31] : (state == SHIFT) ? shreg[31] : 1'b0);
    assign wr_ack     = !rst && load_go && (sel_src == SRC_WR);
    assign frame_done = !rst && gap_done;
    assign busy       = !rst && ((state != IDLE) || init_pend || dis_pend || en_pend || init_rem || wr_req);
    assign des_active = !rst && des_state;

endmodule

// File: tb/tb_adc_cmd_scheduler.sv
// tb/tb_adc_cmd_scheduler.sv - self-checking bench for adc_cmd_scheduler
module tb_adc_cmd_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init = 1'b0, des_enable = 1'b0, des_disable = 1'b0, wr_req = 1'b0;
    logic [3:0]  wr_addr = 4'h0;
    logic [15:0] wr_data = 16'h0;
    logic        wr_ack, busy, frame_done, des_active, sclk, sdata, select;

    adc_cmd_scheduler dut (
        .clk(clk), .rst(rst), .init(init), .des_enable(des_enable), .des_disable(des_disable),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .busy(busy),
        .frame_done(frame_done), .des_active(des_active), .sclk(sclk), .sdata(sdata), .select(select)
    );

    always #5 clk = ~clk;

    int npass = 0;
    int nchk  = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] frames[$];
    int          edges[$];
    int          fd_times[$];
    int          ack_times[$];
    logic [31:0] exp_q[$];
    bit          exp_des;
    logic [31:0] acc = 32'h0;
    int          nedge = 0;
    logic        prev_sclk = 1'b0, prev_sel = 1'b1;

    // Pin-level frame capture: shift on every sclk rise, close the frame when select returns high.
    always @(negedge clk) begin
        if (rst) begin
            acc = 32'h0;
            nedge = 0;
        end else begin
            if (!select && sclk && !prev_sclk) begin
                acc = {acc[30:0], sdata};
                nedge++;
            end
            if (select && !prev_sel) begin
                frames.push_back(acc);
                edges.push_back(nedge);
                acc = 32'h0;
                nedge = 0;
            end
            if (frame_done) fd_times.push_back(cyc);
            if (wr_ack) ack_times.push_back(cyc);
        end
        prev_sclk = sclk;
        prev_sel  = select;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end expected end");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] frm(input logic [3:0] a, input logic [15:0] d);
        return {12'h001, a, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nchk++;
        assert (obs === expv) npass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit i, input bit e, input bit d);
        init = i; des_enable = e; des_disable = d;
        step();
        init = 1'b0; des_enable = 1'b0; des_disable = 1'b0;
    endtask

    task automatic run(input int n, input bit until_idle, output bit idle_seen, output int idle_cyc);
        bit drop;
        idle_seen = 1'b0;
        idle_cyc  = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            drop = wr_ack;
            if (until_idle && !busy) begin
                idle_seen = 1'b1;
                idle_cyc  = cyc;
                break;
            end
            @(posedge clk);
            #1;
            if (drop) wr_req = 1'b0;
        end
        if (idle_seen) step();
    endtask

    task automatic clear_mon();
        frames.delete(); edges.delete(); fd_times.delete(); ack_times.delete(); exp_q.delete();
    endtask

    task automatic check_frames(input string tag);
        chk($sformatf("%s frame count", tag), 32'(frames.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < frames.size(); i++) begin
            chk($sformatf("%s frame %0d", tag, i), frames[i], exp_q[i]);
            chk($sformatf("%s edges %0d", tag, i), 32'(edges[i]), 32'd32);
        end
    endtask

    logic [31:0] e0, e1, e2, dis_f, en_f;

    initial begin
        bit idle;
        int icyc;
        int rise;
        bit ps;
        bit ri, re, rd, rw;
        e0 = 32'h0011B2FF; e1 = 32'h0012007F; e2 = 32'h0013807F;
        dis_f = 32'h00190000; en_f = 32'h00198000;
        exp_des = 1'b0;

        // Requests pulsed while in reset must leave nothing pending.
        init = 1'b1; des_enable = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("rst sclk", 32'(sclk), 0);
        chk("rst sdata", 32'(sdata), 0);
        chk("rst select", 32'(select), 1);
        chk("rst wr_ack", 32'(wr_ack), 0);
        chk("rst frame_done", 32'(frame_done), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst des_active", 32'(des_active), 0);
        step();
        init = 1'b0; des_enable = 1'b0;
        rst = 1'b0;
        clear_mon();
        run(20, 1'b0, idle, icyc);
        chk("post-rst busy", 32'(busy), 0);
        chk("post-rst frames", 32'(frames.size()), 0);

        // init sequence
        clear_mon();
        exp_q = '{e0, e1, e2};
        pulse(1, 0, 0);
        run(2000, 1'b1, idle, icyc);
        chk("init timeout", 32'(idle), 1);
        check_frames("init");
        chk("init fd count", 32'(fd_times.size()), 3);
        if (fd_times.size() == 3) begin
            chk("init spacing 1", 32'(fd_times[1] - fd_times[0]), 265);
            chk("init spacing 2", 32'(fd_times[2] - fd_times[1]), 265);
        end
        chk("init des_active", 32'(des_active), 0);

        // same-cycle enable/disable
        clear_mon();
        exp_q = '{dis_f};
        pulse(0, 1, 1);
        run(1000, 1'b1, idle, icyc);
        chk("both timeout", 32'(idle), 1);
        check_frames("both");
        chk("both des_active", 32'(des_active), 0);

        // lone enable
        clear_mon();
        exp_q = '{en_f};
        pulse(0, 1, 0);
        run(150, 1'b0, idle, icyc);
        chk("en mid des_active", 32'(des_active), 0);
        run(1000, 1'b1, idle, icyc);
        chk("en timeout", 32'(idle), 1);
        check_frames("en");
        chk("en des_active", 32'(des_active), 1);
        if (fd_times.size() == 1) chk("en busy fall", 32'(icyc), 32'(fd_times[0] + 1));

        // user write held through an init sequence
        clear_mon();
        exp_q = '{e0, e1, e2, frm(4'h5, 16'h1234)};
        wr_addr = 4'h5; wr_data = 16'h1234; wr_req = 1'b1;
        pulse(1, 0, 0);
        run(3000, 1'b1, idle, icyc);
        chk("wr-init timeout", 32'(idle), 1);
        check_frames("wr-init");
        chk("wr-init ack count", 32'(ack_times.size()), 1);
        if (ack_times.size() == 1 && fd_times.size() >= 3)
            chk("wr-init ack cycle", 32'(ack_times[0]), 32'(fd_times[2] + 1));

        // enable then disable during a frame
        clear_mon();
        exp_q = '{frm(4'h7, 16'hABCD), dis_f};
        wr_addr = 4'h7; wr_data = 16'hABCD; wr_req = 1'b1;
        run(50, 1'b0, idle, icyc);
        pulse(0, 1, 0);
        run(100, 1'b0, idle, icyc);
        pulse(0, 0, 1);
        run(2000, 1'b1, idle, icyc);
        chk("en-dis timeout", 32'(idle), 1);
        check_frames("en-dis");
        chk("en-dis des_active", 32'(des_active), 0);

        // user write withdrawn before acknowledge
        clear_mon();
        exp_q = '{en_f};
        pulse(0, 1, 0);
        wr_addr = 4'h3; wr_data = 16'h5555; wr_req = 1'b1;
        run(100, 1'b0, idle, icyc);
        wr_req = 1'b0;
        run(1000, 1'b1, idle, icyc);
        chk("cancel timeout", 32'(idle), 1);
        check_frames("cancel");
        chk("cancel ack count", 32'(ack_times.size()), 0);
        chk("cancel des_active", 32'(des_active), 1);

        // init restart during the second entry
        clear_mon();
        exp_q = '{e0, e1, e0, e1, e2};
        pulse(1, 0, 0);
        run(365, 1'b0, idle, icyc);
        pulse(1, 0, 0);
        run(3000, 1'b1, idle, icyc);
        chk("restart timeout", 32'(idle), 1);
        check_frames("restart");

        // reset during bit 10
        clear_mon();
        pulse(0, 0, 1);
        rise = 0;
        ps = 1'b0;
        for (int k = 0; k < 400 && rise < 10; k++) begin
            @(negedge clk);
            if (sclk && !ps) rise++;
            ps = sclk;
        end
        for (int k = 0; k < 20 && sclk; k++) @(negedge clk);
        chk("abort reached bit 10", 32'(rise), 10);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort select", 32'(select), 1);
        chk("abort sclk", 32'(sclk), 0);
        chk("abort busy", 32'(busy), 0);
        chk("abort des_active", 32'(des_active), 0);
        step();
        rst = 1'b0;
        run(400, 1'b0, idle, icyc);
        chk("abort frames", 32'(frames.size()), 0);
        chk("abort frame_done", 32'(fd_times.size()), 0);
        chk("abort busy after", 32'(busy), 0);
        exp_des = 1'b0;

        // randomized same-cycle request mixes against the priority model
        for (int it = 0; it < 12; it++) begin
            clear_mon();
            ri = ($urandom_range(0, 3) == 0);
            re = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            rw = 1'($urandom_range(0, 1));
            if (!ri && !re && !rd && !rw) rw = 1'b1;
            wr_addr = 4'($urandom_range(0, 15));
            wr_data = 16'($urandom);
            if (ri) begin exp_q.push_back(e0); exp_q.push_back(e1); exp_q.push_back(e2); end
            if (rd) begin exp_q.push_back(dis_f); exp_des = 1'b0; end
            else if (re) begin exp_q.push_back(en_f); exp_des = 1'b1; end
            if (rw) exp_q.push_back(frm(wr_addr, wr_data));
            wr_req = rw;
            pulse(ri, re, rd);
            run(2500, 1'b1, idle, icyc);
            chk($sformatf("rand%0d timeout", it), 32'(idle), 1);
            check_frames($sformatf("rand%0d", it));
            chk($sformatf("rand%0d des_active", it), 32'(des_active), 32'(exp_des));
            chk($sformatf("rand%0d ack count", it), 32'(ack_times.size()), 32'(rw));
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
